// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers (pc, instr) pairs between fetch and decode.
// Defining FETCH_QUEUE_BYPASS_EN lets an empty queue pass a push straight to the outputs.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_valid_i,
    input  logic [DATA_W-1:0]        pc_i,
    input  logic [DATA_W-1:0]        instr_i,
    output logic                     push_ready_o,
    input  logic                     pop_ready_i,
    output logic                     pop_valid_o,
    output logic [DATA_W-1:0]        pc_o,
    output logic [DATA_W-1:0]        pc_plus4_o,
    output logic [DATA_W-1:0]        instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic empty;
    logic full;
    logic bypass_hit;
    logic push_fire;
    logic pop_fire;
    logic do_push;
    logic do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Ready is a pure function of occupancy (and reset), never of pop_ready_i.
    assign push_ready_o = !rst_i && !full;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = !rst_i && empty && push_valid_i && !flush_i;
`else
    assign bypass_hit = 1'b0;
`endif

    assign pop_valid_o = !empty || bypass_hit;
    assign push_fire   = push_valid_i && push_ready_o && !flush_i;
    assign pop_fire    = pop_valid_o && pop_ready_i && !flush_i;
    // A bypassed entry consumed in the same cycle is never written to storage.
    assign do_push     = push_fire && !(bypass_hit && pop_ready_i);
    assign do_pop      = pop_fire && !empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (do_push) begin
            pc_mem[wr_ptr]    <= pc_i;
            instr_mem[wr_ptr] <= instr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_comb begin
        pc_o       = '0;
        instr_o    = '0;
        pc_plus4_o = '0;
        if (!empty) begin
            pc_o       = pc_mem[rd_ptr];
            instr_o    = instr_mem[rd_ptr];
            pc_plus4_o = pc_mem[rd_ptr] + DATA_W'(4);
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (bypass_hit) begin
            pc_o       = pc_i;
            instr_o    = instr_i;
            pc_plus4_o = pc_i + DATA_W'(4);
        end
`endif
    end

    assign count_o = count;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the PC and instruction width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit: discards all queued entries (branch/jump redirect).
REQ-006 The block SHALL have port push_valid_i, input, 1 bit: fetch side presents a valid pc_i/instr_i pair.
REQ-007 The block SHALL have port pc_i, input, DATA_W bits: address of the fetched instruction, from the program counter.
REQ-008 The block SHALL have port instr_i, input, DATA_W bits: instruction word read from instruction memory at pc_i.
REQ-009 The block SHALL have port push_ready_o, output, 1 bit: queue can accept a push; drives the program counter's write enable.
REQ-010 The block SHALL have port pop_ready_i, input, 1 bit: decode stage accepts the head entry this cycle.
REQ-011 The block SHALL have port pop_valid_o, output, 1 bit: head entry is valid.
REQ-012 The block SHALL have port pc_o, output, DATA_W bits: PC of the head entry.
REQ-013 The block SHALL have port pc_plus4_o, output, DATA_W bits: pc_o + 4, modulo 2^DATA_W.
REQ-014 The block SHALL have port instr_o, output, DATA_W bits: instruction of the head entry.
REQ-015 The block SHALL have port count_o, output, log2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-016 A push SHALL occur on a rising edge when push_valid_i and push_ready_o are both 1 and flush_i is 0.
REQ-017 A pop SHALL occur on a rising edge when pop_valid_o and pop_ready_i are both 1 and flush_i is 0.
REQ-018 push_ready_o SHALL equal (count_o != DEPTH) and SHALL NOT depend combinationally on pop_ready_i; a full queue SHALL refuse a push even in a popping cycle.
REQ-019 pop_valid_o SHALL equal (count_o != 0), except as extended by REQ-030.
REQ-020 When count_o = 0, pc_o, instr_o and pc_plus4_o SHALL all be 0.
REQ-021 Entries SHALL leave in push order; read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 A simultaneous push and pop on a non-empty, non-full queue SHALL leave count_o unchanged.
REQ-023 flush_i = 1 SHALL, at the next edge, set count_o to 0 and both pointers to 0; any push or pop in that cycle SHALL be discarded.
REQ-024 push_ready_o SHALL be 1 during a flush cycle whenever the queue was not full; a push accepted by handshake in that cycle is still discarded, and the fetch side re-fetches from the redirected PC.
REQ-025 Without bypass, an entry pushed at edge N SHALL be visible at the outputs after edge N (latency 1 cycle).
REQ-026 A push attempted while full, or a pop attempted while empty, SHALL leave all state unchanged.

Reset
REQ-027 While rst_i = 1, the block SHALL asynchronously force count_o = 0, both pointers = 0, all storage = 0, pop_valid_o = 0 and push_ready_o = 0.
REQ-028 After rst_i deasserts, push_ready_o SHALL be 1 and all data outputs SHALL be 0 until the first push.
REQ-029 Reset asserted mid-operation SHALL discard all entries, taking priority over flush_i, pushes and pops.

Configuration
REQ-030 With macro FETCH_QUEUE_BYPASS_EN defined, an empty queue receiving push_valid_i = 1 with flush_i = 0 SHALL drive pop_valid_o = 1 and present pc_i/instr_i combinationally on the outputs; if pop_ready_i = 1 the entry SHALL be consumed without being stored (count_o stays 0), otherwise it SHALL be stored normally.
REQ-031 With FETCH_QUEUE_BYPASS_EN undefined, no combinational path SHALL exist from any push-side input to pop_valid_o, pc_o, pc_plus4_o or instr_o.

Verification
REQ-032 Reset release, then four pushes of pc 0x00,0x04,0x08,0x0C with pop_ready_i = 0 -> count_o = 4, push_ready_o = 0, pc_o = 0x00, pc_plus4_o = 0x04.
REQ-033 From full, hold push_valid_i = 1 with pc 0x10 and pop once -> 0x00 leaves, 0x10 is not accepted that cycle, count_o = 3, and 0x10 enters on the next edge.
REQ-034 Run 10 push/pop cycles with DEPTH = 4 so pointers wrap twice -> pop order equals push order exactly.
REQ-035 With 3 entries queued, assert flush_i together with a push of pc 0x40 -> count_o = 0, pop_valid_o = 0 and pc_o = 0 on the next cycle.
REQ-036 With bypass defined, on an empty queue push pc 0x80 with pop_ready_i = 1 -> pop_valid_o = 1 and pc_o = 0x80 in the same cycle, and count_o stays 0; with bypass undefined -> pop_valid_o = 0 in that cycle.
REQ-037 Assert rst_i mid-cycle with 2 entries queued -> count_o = 0 and pop_valid_o = 0 immediately, without waiting for a clock edge.
